// File: rtl/hamming_rx_sequencer.sv
// Receive-side sequencer: pairs Hamming (8,4) codewords from the UART, runs each one
// through the external combinational decoder, rebuilds the byte and keeps error counts.
module hamming_rx_sequencer #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  output logic [7:0]  dec_code_o,
  input  logic [3:0]  dec_data_i,
  input  logic        dec_single_i,
  input  logic        dec_double_i,
  output logic        out_valid_o,
  output logic [7:0]  out_data_o,
  output logic        out_corrected_o,
  input  logic        out_ready_i,
  output logic        err_drop_o,
  output logic        err_timeout_o,
  input  logic        clr_cnt_i,
  output logic [15:0] cnt_corrected_o,
  output logic [15:0] cnt_dropped_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOW_DEC = 3'd1,
    S_WAIT_HI = 3'd2,
    S_HI_DEC  = 3'd3,
    S_OUT     = 3'd4
  } state_e;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  state_e      state_q;
  logic [7:0]  code_q;
  logic [7:0]  data_q;
  logic [3:0]  lo_q;
  logic        corr_q;
  logic        bad_q;
  logic        drop_q;
  logic        tmo_q;
  logic [15:0] tmr_q;
  logic [15:0] cnt_corr_q, cnt_corr_d;
  logic [15:0] cnt_drop_q, cnt_drop_d;

  logic        accept;
  logic        tmr_expire;
  logic        hi_bad;
  logic        inc_corr;
  logic        inc_drop;

  // Handshakes: a codeword moves on a rising edge with rx_valid_i & rx_ready_o high;
  // a byte moves on a rising edge with out_valid_o & out_ready_i high. The sender
  // holds valid and data steady until the transfer happens.
  assign rx_ready_o = (state_q == S_IDLE) || (state_q == S_WAIT_HI);
  assign accept     = rx_valid_i && rx_ready_o;

  assign tmr_expire = (state_q == S_WAIT_HI) && !rx_valid_i && (tmr_q == TMO_LAST);
  assign hi_bad     = bad_q || dec_double_i;
  assign inc_corr   = ((state_q == S_LOW_DEC) || (state_q == S_HI_DEC)) && dec_single_i;
  assign inc_drop   = tmr_expire || ((state_q == S_HI_DEC) && hi_bad);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      code_q  <= 8'h00;
      data_q  <= 8'h00;
      lo_q    <= 4'h0;
      corr_q  <= 1'b0;
      bad_q   <= 1'b0;
      drop_q  <= 1'b0;
      tmo_q   <= 1'b0;
      tmr_q   <= 16'h0000;
    end else begin
      drop_q <= 1'b0;
      tmo_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            code_q  <= rx_data_i;
            bad_q   <= 1'b0;
            corr_q  <= 1'b0;
            state_q <= S_LOW_DEC;
          end
        end
        S_LOW_DEC: begin
          lo_q  <= dec_data_i;
          tmr_q <= 16'h0000;
          if (dec_single_i) corr_q <= 1'b1;
          if (dec_double_i) bad_q <= 1'b1;
          state_q <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          // A bad low codeword still consumes the next codeword as its partner.
          if (accept) begin
            code_q  <= rx_data_i;
            state_q <= S_HI_DEC;
          end else if (tmr_expire) begin
            tmo_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            tmr_q <= tmr_q + 16'd1;
          end
        end
        S_HI_DEC: begin
          if (dec_single_i) corr_q <= 1'b1;
          if (hi_bad) begin
            bad_q   <= 1'b1;
            drop_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            data_q  <= {dec_data_i, lo_q};
            state_q <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Clear wins over a same-cycle increment; both counters stick at all-ones.
  always_comb begin
    cnt_corr_d = cnt_corr_q;
    cnt_drop_d = cnt_drop_q;
    if (clr_cnt_i) begin
      cnt_corr_d = 16'h0000;
      cnt_drop_d = 16'h0000;
    end else begin
      if (inc_corr && (cnt_corr_q != CNT_MAX)) cnt_corr_d = cnt_corr_q + 16'd1;
      if (inc_drop && (cnt_drop_q != CNT_MAX)) cnt_drop_d = cnt_drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_corr_q <= 16'h0000;
      cnt_drop_q <= 16'h0000;
    end else begin
      cnt_corr_q <= cnt_corr_d;
      cnt_drop_q <= cnt_drop_d;
    end
  end

  assign dec_code_o      = code_q;
  assign out_valid_o     = (state_q == S_OUT);
  assign out_data_o      = data_q;
  assign out_corrected_o = corr_q;
  assign err_drop_o      = drop_q;
  assign err_timeout_o   = tmo_q;
  assign cnt_corrected_o = cnt_corr_q;
  assign cnt_dropped_o   = cnt_drop_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_hamming_rx_sequencer.sv
// Directed bench for hamming_rx_sequencer with a behavioural SECDED decoder in the loop:
// table of codeword pairs plus hand-written timeout, backpressure, reset and counter cases.
module tb_hamming_rx_sequencer;

  localparam int unsigned TMO = 8;

  logic        clk;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [7:0]  dec_code;
  logic [3:0]  dec_data;
  logic        dec_single;
  logic        dec_double;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_corrected;
  logic        out_ready;
  logic        err_drop;
  logic        err_timeout;
  logic        clr_cnt;
  logic [15:0] cnt_corrected;
  logic [15:0] cnt_dropped;
  logic [2:0]  state;

  hamming_rx_sequencer #(.TIMEOUT(TMO)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .rx_valid_i      (rx_valid),
    .rx_data_i       (rx_data),
    .rx_ready_o      (rx_ready),
    .dec_code_o      (dec_code),
    .dec_data_i      (dec_data),
    .dec_single_i    (dec_single),
    .dec_double_i    (dec_double),
    .out_valid_o     (out_valid),
    .out_data_o      (out_data),
    .out_corrected_o (out_corrected),
    .out_ready_i     (out_ready),
    .err_drop_o      (err_drop),
    .err_timeout_o   (err_timeout),
    .clr_cnt_i       (clr_cnt),
    .cnt_corrected_o (cnt_corrected),
    .cnt_dropped_o   (cnt_dropped),
    .state_o         (state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- decoder model ----------------
  // Extended Hamming (8,4): enc(5)=0x9A, enc(A)=0x65; nearest codeword decoding.
  function automatic logic [7:0] enc(input logic [3:0] d);
    logic [7:0] c;
    c = 8'h00;
    if (d[0]) c = c ^ 8'hCC;
    if (d[1]) c = c ^ 8'hF0;
    if (d[2]) c = c ^ 8'h56;
    if (d[3]) c = c ^ 8'h95;
    return c;
  endfunction

  always_comb begin
    dec_data   = 4'h0;
    dec_single = 1'b0;
    dec_double = 1'b1;
    for (int d = 0; d < 16; d++) begin
      if ($countones(dec_code ^ enc(4'(d))) == 0) begin
        dec_data   = 4'(d);
        dec_single = 1'b0;
        dec_double = 1'b0;
      end else if ($countones(dec_code ^ enc(4'(d))) == 1) begin
        dec_data   = 4'(d);
        dec_single = 1'b1;
        dec_double = 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int exp_cc   = 0;
  int exp_cd   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    logic       valid;
    logic [7:0] data;
    logic       corr;
    int         dcc;
    int         dcd;
  } vec_t;

  // ---------------- driver ----------------
  // Starts and ends in IDLE, #1 after a rising edge. Low accepted at T, high at U=T+2.
  task automatic send_pair(input vec_t v, input int hold);
    logic [7:0] exp_byte;
    check("idle_rx_ready", rx_ready, 1'b1);
    rx_valid = 1'b1;
    rx_data  = v.lo;
    tick();
    check("dec_code_lo", dec_code, v.lo);
    check("low_dec_rx_ready", rx_ready, 1'b0);
    rx_valid = 1'b0;
    tick();
    check("wait_hi_state", state, 3'd2);
    rx_valid = 1'b1;
    rx_data  = v.hi;
    tick();
    check("dec_code_hi", dec_code, v.hi);
    rx_valid = 1'b0;
    tick();
    exp_cc = sat16(exp_cc + v.dcc);
    exp_cd = sat16(exp_cd + v.dcd);
    if (v.valid) exp_q.push_back(v.data);
    check("out_valid", out_valid, v.valid);
    check("err_drop", err_drop, !v.valid);
    check("err_timeout_quiet", err_timeout, 1'b0);
    check("cnt_corrected", cnt_corrected, exp_cc[15:0]);
    check("cnt_dropped", cnt_dropped, exp_cd[15:0]);
    if (v.valid) begin
      exp_byte = exp_q.pop_front();
      check("out_data", out_data, exp_byte);
      check("out_corrected", out_corrected, v.corr);
      for (int i = 0; i < hold; i++) begin
        tick();
        check("hold_out_valid", out_valid, 1'b1);
        check("hold_out_data", out_data, exp_byte);
        check("hold_rx_ready", rx_ready, 1'b0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("after_out_valid", out_valid, 1'b0);
    end
    check("end_state_idle", state, 3'd0);
  endtask

  vec_t vecs[9];

  // ---------------- test ----------------
  initial begin
    vecs[0] = '{8'h9A, 8'h65, 1'b1, 8'hA5, 1'b0, 0, 0};
    vecs[1] = '{8'h98, 8'h65, 1'b1, 8'hA5, 1'b1, 1, 0};
    vecs[2] = '{8'h9A, 8'h66, 1'b0, 8'h00, 1'b0, 0, 1};
    vecs[3] = '{8'h00, 8'hFF, 1'b1, 8'hF0, 1'b0, 0, 0};
    vecs[4] = '{8'hCC, 8'hC3, 1'b1, 8'hC1, 1'b0, 0, 0};
    vecs[5] = '{8'h3C, 8'h94, 1'b1, 8'h83, 1'b1, 1, 0};
    vecs[6] = '{8'h57, 8'hF3, 1'b0, 8'h00, 1'b0, 1, 1};
    vecs[7] = '{8'h03, 8'hFF, 1'b0, 8'h00, 1'b0, 0, 1};
    vecs[8] = '{8'h01, 8'hFE, 1'b1, 8'hF0, 1'b1, 2, 0};

    rst_n     = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    out_ready = 1'b0;
    clr_cnt   = 1'b0;
    tick();
    tick();
    check("rst_state", state, 3'd0);
    check("rst_rx_ready", rx_ready, 1'b1);
    check("rst_dec_code", dec_code, 8'h00);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_cnt_corrected", cnt_corrected, 16'h0000);
    check("rst_cnt_dropped", cnt_dropped, 16'h0000);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) send_pair(vecs[i], 0);

    // Timeout: only a low codeword arrives.
    rx_valid = 1'b1;
    rx_data  = 8'h9A;
    tick();
    rx_valid = 1'b0;
    tick();
    for (int k = 0; k < int'(TMO); k++) begin
      check("tmo_wait_quiet", err_timeout, 1'b0);
      check("tmo_wait_ready", rx_ready, 1'b1);
      tick();
    end
    exp_cd = sat16(exp_cd + 1);
    check("tmo_pulse", err_timeout, 1'b1);
    check("tmo_cnt_dropped", cnt_dropped, exp_cd[15:0]);
    check("tmo_state_idle", state, 3'd0);
    check("tmo_rx_ready", rx_ready, 1'b1);
    tick();
    check("tmo_pulse_end", err_timeout, 1'b0);
    send_pair(vecs[0], 0);

    // Backpressure in OUT.
    send_pair(vecs[1], 10);

    // Reset in the middle of a pair.
    rx_valid = 1'b1;
    rx_data  = 8'h98;
    tick();
    rx_valid = 1'b0;
    tick();
    check("mid_pair_cnt_corrected", cnt_corrected, 16'(exp_cc + 1));
    rst_n = 1'b0;
    #1;
    exp_cc = 0;
    exp_cd = 0;
    check("mid_rst_state", state, 3'd0);
    check("mid_rst_dec_code", dec_code, 8'h00);
    check("mid_rst_out_data", out_data, 8'h00);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_corrected", out_corrected, 1'b0);
    check("mid_rst_err_drop", err_drop, 1'b0);
    check("mid_rst_err_timeout", err_timeout, 1'b0);
    check("mid_rst_cnt_corrected", cnt_corrected, 16'h0000);
    check("mid_rst_cnt_dropped", cnt_dropped, 16'h0000);
    tick();
    rst_n = 1'b1;
    tick();
    send_pair(vecs[0], 0);

    // Saturation: preload counters just below / at all-ones.
    force dut.cnt_corr_q = 16'hFFFE;
    force dut.cnt_drop_q = 16'hFFFF;
    tick();
    release dut.cnt_corr_q;
    release dut.cnt_drop_q;
    exp_cc = 65534;
    exp_cd = 65535;
    check("preload_cnt_corrected", cnt_corrected, 16'hFFFE);
    send_pair('{8'h98, 8'h64, 1'b1, 8'hA5, 1'b1, 2, 0}, 0);
    send_pair(vecs[1], 0);
    send_pair(vecs[2], 0);

    // Clear in the same cycle as a corrected-count increment.
    rx_valid = 1'b1;
    rx_data  = 8'h98;
    tick();
    rx_valid = 1'b0;
    clr_cnt  = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("clr_cnt_corrected", cnt_corrected, 16'h0000);
    check("clr_cnt_dropped", cnt_dropped, 16'h0000);
    rx_valid = 1'b1;
    rx_data  = 8'h65;
    tick();
    rx_valid = 1'b0;
    tick();
    check("clr_out_valid", out_valid, 1'b1);
    check("clr_out_data", out_data, 8'hA5);
    check("clr_out_corrected", out_corrected, 1'b1);
    check("clr_cnt_after", cnt_corrected, 16'h0000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("clr_end_idle", state, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hamming_rx_sequencer.md
# hamming_rx_sequencer

Receive-side controller that sequences the team's combinational Hamming (8,4) SECDED decoder between the UART receiver and the byte consumer. Accepts Hamming codewords from the UART RX (low nibble first, then high nibble) and drives each one to the decoder through a registered port. Samples the decoder's data and error flags, reassembles the byte and presents it on a valid/ready output. Drops bytes with uncorrectable errors or an incomplete pair, and keeps saturating error statistics.

## Interface
- TIMEOUT, 1000: max cycles spent in WAIT_HI before the pair is aborted (1..65535)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rx_valid  in  1  codeword available from UART RX
- rx_data  in  8  received codeword
- rx_ready  out  1  sequencer accepts codeword this cycle
- dec_code  out  8  registered codeword driven to decoder input
- dec_data  in  4  decoder corrected data nibble
- dec_single  in  1  decoder single-error (corrected) flag
- dec_double  in  1  decoder double-error flag
- out_valid  out  1  reassembled byte valid
- out_data  out  8  {high nibble, low nibble}
- out_corrected  out  1  at least one codeword of this byte was corrected; valid with out_valid
- out_ready  in  1  consumer accepts byte
- err_drop  out  1  one-cycle pulse: byte discarded due to double error
- err_timeout  out  1  one-cycle pulse: high codeword missing, pair aborted
- clr_cnt  in  1  synchronous clear of both counters
- cnt_corrected  out  16  codewords with single error, saturating
- cnt_dropped  out  16  bytes dropped (double error or timeout), saturating

## Operation
- States: IDLE, LOW_DEC, WAIT_HI, HI_DEC, OUT.
- rx_ready = 1 in IDLE and WAIT_HI, else 0 (combinational from state).
- IDLE: on rx_valid&rx_ready, load dec_code <= rx_data, clear the bad flag, go to LOW_DEC.
- LOW_DEC: sample dec_data into the low nibble. If dec_single, set the corrected flag and increment cnt_corrected. If dec_double, set the sticky bad flag. Clear the timeout counter and go to WAIT_HI.
- WAIT_HI:
  - On accept, load dec_code and go to HI_DEC.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT, pulse err_timeout, increment cnt_dropped and go to IDLE.
  - The pairing is kept even if the low codeword was bad.
- HI_DEC: sample the high nibble and flags as in LOW_DEC.
  - If bad (from either codeword): pulse err_drop, increment cnt_dropped, go to IDLE; no out_valid.
  - Else go to OUT.
- OUT: out_valid = 1, and out_data/out_corrected are held stable. On out_ready, go to IDLE.
- Counters saturate at 16'hFFFF. clr_cnt has priority over a same-cycle increment (result 0).
- dec_single and dec_double are sampled only in LOW_DEC/HI_DEC and ignored in other states.
- Reset (rst_n low), effective immediately mid-operation:
  - State = IDLE; dec_code = 8'h00, out_data = 8'h00.
  - out_valid, out_corrected, err_drop, err_timeout = 0.
  - Both counters = 0; timeout counter, corrected flag and bad flag cleared.
  - A partially received pair is discarded with no error pulse.

## Timing
- Codeword accepted at cycle T: dec_code is valid from T+1. Decoder outputs are sampled at the end of T+1 (decoder is combinational, one-cycle path from dec_code).
- Low accepted at T and high accepted at U: out_valid rises at U+2, or err_drop pulses at U+2.
- Counter updates are visible the cycle after the sampling cycle.
- Back-to-back minimum: 5 cycles per byte with out_ready held high.
- err_timeout asserts exactly TIMEOUT cycles after entering WAIT_HI.
- No codeword is accepted while in LOW_DEC, HI_DEC or OUT; the UART RX must hold rx_valid/rx_data until accepted.

## Test plan
- Clean byte (bench instantiates the team's decoder): send 0x9A then 0x65.
  - Required: out_valid with out_data=0xA5, out_corrected=0, counters 0, latency U+2.
- Single error: send 0x98, 0x65.
  - Required: out_data=0xA5, out_corrected=1, cnt_corrected=1, no error pulses.
- Double error on high codeword: send 0x9A, 0x66.
  - Required: err_drop pulse at U+2, no out_valid, cnt_dropped=1.
- Timeout: TIMEOUT=8, send only 0x9A.
  - Required: err_timeout pulse 8 cycles after WAIT_HI entry, cnt_dropped=1, rx_ready=1 afterwards.
  - Then send 0x9A, 0x65; required: 0xA5 is output normally.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles in OUT. Required: out_data stable, rx_ready=0.
  - Assert rst_n low mid-pair. Required: all outputs 0, state IDLE.
- Counters: force cnt_corrected to saturation with 0x98/0x65 pairs. Required: it stays at 0xFFFF.
  - Assert clr_cnt in the same cycle as an increment. Required: both counters read 0.
